vpe_pkt_fetch: RTL and testbench
================================

# vpe_pkt_fetch

Upstream feeder of the VPE controller. Collects one feature packet from a word-serial input stream into a `LANES`-wide vector, then raises `pkt_fea_valid` for one cycle so the controller leaves its fetch state. It is driven by the controller's `fetch_pkt_fea` request. It holds the published vector stable through the whole run phase, and accounts for short and over-long packets.

## Interface
Parameters:
- `LANES`, 8, number of feature lanes per packet (2..15)
- `DW`, 8, bits per feature word
- `LW`, `$clog2(LANES+1)`, width of the lane-count output

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `fetch_pkt_fea`  in  1  request level from the controller; high while the controller is in its fetch state
- `pkt_fea_valid`  out  1  one-cycle pulse: new vector published
- `fea_vec`  out  `LANES*DW`  published feature vector; lane i is `[i*DW +: DW]`
- `fea_len`  out  `LW`  number of real (non-padded) lanes in `fea_vec`
- `s_valid`  in  1  stream word valid
- `s_ready`  out  1  stream word ready (registered)
- `s_data`  in  `DW`  stream word
- `s_last`  in  1  last word of the packet
- `pkt_cnt`  out  16  packets published, wraps at 0xFFFF→0
- `err_short`  out  1  sticky: a packet ended before `LANES` words
- `err_overlen`  out  1  sticky: a packet exceeded `LANES` words

## Operation
- FSM states: IDLE, COLLECT, DISCARD, DONE, WAIT_LOW. Reset state is IDLE.
- A beat is accepted on `s_valid && s_ready`. `s_ready` = 1 only in COLLECT and DISCARD.
- IDLE: if `fetch_pkt_fea`=1, go to COLLECT, clear the shadow buffer to 0, and set lane index `idx` to 0.
- COLLECT, on each accepted beat, write `s_data` to shadow lane `idx`, then:
  - `s_last`=1: go to DONE with length `idx+1`. If `idx+1 < LANES`, set `err_short`; unfilled lanes remain 0.
  - `s_last`=0 and `idx == LANES-1`: go to DISCARD with length `LANES`.
  - otherwise: `idx` increments.
- DISCARD: accepted beats are dropped. On an accepted beat with `s_last`=1, set `err_overlen` and go to DONE.
- Transition into DONE, on that clock edge:
  - `fea_vec` ← shadow and `fea_len` ← length
  - `pkt_cnt` ← `pkt_cnt+1`
  - `pkt_fea_valid` ← 1
- DONE lasts exactly 1 cycle, then goes to WAIT_LOW with `pkt_fea_valid` ← 0.
- WAIT_LOW: stay while `fetch_pkt_fea`=1. The controller's request lingers one cycle after the pulse; this lingering high must NOT start a new collection. When `fetch_pkt_fea`=0, go to IDLE.
- `fetch_pkt_fea` dropping during COLLECT or DISCARD does not abort; the packet completes normally.
- `fea_vec` and `fea_len` change only on entry to DONE. They are stable from then until the next DONE.
- The shadow buffer is separate from `fea_vec`, so collecting the next packet never disturbs the published vector.
- Error flags are sticky and cleared only by `rst`. Both may be set over the block's lifetime.

## Timing
- Reset values: `pkt_fea_valid`=0, `s_ready`=0, `fea_vec`=0, `fea_len`=0, `pkt_cnt`=0, `err_short`=0, `err_overlen`=0, FSM=IDLE, `idx`=0.
- Reset asserted mid-packet aborts immediately. Partial data is lost; there is no pulse.
- Request edge N (`fetch_pkt_fea` sampled 1 in IDLE) → `s_ready`=1 from cycle N+1.
- Beat accepted with `s_last` at edge M → `pkt_fea_valid`=1 and `s_ready`=0 during cycle M+1. The new `fea_vec` is visible in the same cycle M+1.
- Minimum request-to-pulse latency is `k+1` cycles for a k-word packet with `s_valid` held high.
- Back-to-back beats are accepted every cycle with no bubbles. Stalls on `s_valid`=0 are unlimited.
- Once WAIT_LOW sees `fetch_pkt_fea`=0, the next request is accepted at the earliest 2 cycles after that (via IDLE).

## Test plan
- Reset → all outputs at reset values. Controller request with `LANES`=8 and 8 beats 0x01..0x08, `s_last` on the 8th:
  - one pulse, `fea_vec`=0x0807060504030201, `fea_len`=8
  - `pkt_cnt`=1, no error flags
- Short packet: beats 0xAA, 0xBB with `s_last` → `fea_vec`=0x000000000000BBAA, `fea_len`=2, `err_short`=1.
- Over-long packet: 11 beats 0x10..0x1A, `s_last` on 0x1A:
  - `fea_vec` lanes hold 0x10..0x17, `fea_len`=8
  - `err_overlen`=1, pulse one cycle after 0x1A is accepted
- Lingering request: `fetch_pkt_fea` held 1 for 2 cycles after the pulse → no second collection, `s_ready` stays 0. The next request collects normally and `pkt_cnt`=2.
- Stalls and stability: random `s_valid` gaps during a packet give correct lanes. `fea_vec` stays unchanged throughout the next packet's COLLECT until its pulse.
- Reset mid-COLLECT after 3 beats → outputs return to reset values, no pulse. The following full packet is collected correctly with `pkt_cnt`=1.

Source files
------------

// File: rtl/vpe_pkt_fetch_if.sv
// Word-serial feature stream into the VPE packet fetcher.
// Source drives valid/data/last; the fetcher returns a registered ready.
interface vpe_pkt_fetch_if #(
    parameter int DW = 8
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/vpe_pkt_fetch.sv
// VPE feature packet fetcher: gathers one packet into a shadow buffer,
// publishes it to the controller with a one-cycle pulse, tracks errors.
module vpe_pkt_fetch #(
    parameter int LANES = 8,
    parameter int DW    = 8,
    parameter int LW    = $clog2(LANES+1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_pkt_fea,
    output logic                pkt_fea_valid,
    output logic [LANES*DW-1:0] fea_vec,
    output logic [LW-1:0]       fea_len,
    vpe_pkt_fetch_if.slave      s,
    output logic [15:0]         pkt_cnt,
    output logic                err_short,
    output logic                err_overlen
);
    localparam int IW = $clog2(LANES);

    typedef enum logic [2:0] {
        IDLE, COLLECT, DISCARD, DONE, WAIT_LOW
    } state_t;

    state_t              state, state_nx;
    logic [IW-1:0]       idx;
    logic [LANES*DW-1:0] shadow, shadow_wr;
    logic                beat, at_end;
    logic                ready_nx, valid_nx;

    assign beat   = s.s_valid && s.s_ready;
    assign at_end = (idx == IW'(LANES-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (fetch_pkt_fea) state_nx = COLLECT;
            COLLECT:
                if (beat) begin
                    if (s.s_last)    state_nx = DONE;
                    else if (at_end) state_nx = DISCARD;
                end
            DISCARD:  if (beat && s.s_last) state_nx = DONE;
            DONE:     state_nx = WAIT_LOW;
            WAIT_LOW: if (!fetch_pkt_fea) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Ready and pulse are registered off the next state
    always_comb begin
        ready_nx = (state_nx == COLLECT) || (state_nx == DISCARD);
        valid_nx = (state_nx == DONE);
    end

    always_comb begin
        shadow_wr = shadow;
        shadow_wr[idx*DW +: DW] = s.s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s.s_ready     <= 1'b0;
            pkt_fea_valid <= 1'b0;
        end else begin
            s.s_ready     <= ready_nx;
            pkt_fea_valid <= valid_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            shadow <= '0;
        end else if (state == IDLE && fetch_pkt_fea) begin
            idx    <= '0;
            shadow <= '0;
        end else if (state == COLLECT && beat) begin
            shadow <= shadow_wr;
            if (!s.s_last && !at_end) idx <= idx + 1'b1;
        end
    end

    // A packet reaching DONE from DISCARD always filled every lane
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fea_vec     <= '0;
            fea_len     <= '0;
            pkt_cnt     <= '0;
            err_short   <= 1'b0;
            err_overlen <= 1'b0;
        end else if (state_nx == DONE && state != DONE) begin
            pkt_cnt <= pkt_cnt + 16'd1;
            if (state == COLLECT) begin
                fea_vec <= shadow_wr;
                fea_len <= LW'(idx) + LW'(1);
                if (!at_end) err_short <= 1'b1;
            end else begin
                fea_vec     <= shadow;
                fea_len     <= LW'(LANES);
                err_overlen <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vpe_pkt_fetch.sv
// Randomized bench for vpe_pkt_fetch against a packet-level model.
// Model derives vector, length and flags from the whole word list.
module tb_vpe_pkt_fetch;
    localparam int LANES = 8;
    localparam int DW    = 8;
    localparam int LW    = $clog2(LANES+1);
    localparam int VW    = LANES*DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetch_pkt_fea = 1'b0;
    logic          pkt_fea_valid;
    logic [VW-1:0] fea_vec;
    logic [LW-1:0] fea_len;
    logic [15:0]   pkt_cnt;
    logic          err_short, err_overlen;

    vpe_pkt_fetch_if #(.DW(DW)) sif ();

    vpe_pkt_fetch #(.LANES(LANES), .DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_pkt_fea (fetch_pkt_fea),
        .pkt_fea_valid (pkt_fea_valid),
        .fea_vec       (fea_vec),
        .fea_len       (fea_len),
        .s             (sif.slave),
        .pkt_cnt       (pkt_cnt),
        .err_short     (err_short),
        .err_overlen   (err_overlen)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] pkt_q[$];
    logic [VW-1:0] m_vec;
    int            m_len;
    int            m_cnt;
    bit            m_short, m_over;

    task automatic chk(input string tag, input logic [VW-1:0] got,
                       input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, VW'(pkt_fea_valid), '0);
        chk({tag, "_ready"}, VW'(sif.s_ready), '0);
        chk({tag, "_vec"}, fea_vec, '0);
        chk({tag, "_len"}, VW'(fea_len), '0);
        chk({tag, "_cnt"}, VW'(pkt_cnt), '0);
        chk({tag, "_short"}, VW'(err_short), '0);
        chk({tag, "_over"}, VW'(err_overlen), '0);
    endtask

    task automatic model_publish();
        int n;
        n = pkt_q.size();
        m_vec = '0;
        for (int i = 0; i < n && i < LANES; i++)
            m_vec = m_vec | (VW'(pkt_q[i]) << (i*DW));
        m_len = (n < LANES) ? n : LANES;
        m_cnt = (m_cnt + 1) % 65536;
        if (n < LANES) m_short = 1'b1;
        if (n > LANES) m_over  = 1'b1;
    endtask

    // Call at #1 after an edge with the DUT in IDLE
    task automatic run_pkt(input int stall_pct, input int linger,
                           input bit drop_early);
        int  lat, i, cyc, n;
        bit  done, v, acc;
        n = pkt_q.size();
        fetch_pkt_fea = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!sif.s_ready && lat < 4);
        chk("req_lat", VW'(lat), VW'(1));
        i = 0; cyc = 0; done = 0;
        while (!done && cyc < 500) begin
            v = ($urandom_range(0, 99) >= stall_pct);
            sif.s_valid = v;
            sif.s_data  = pkt_q[i];
            sif.s_last  = (i == n-1);
            acc = v && sif.s_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc && drop_early) fetch_pkt_fea = 1'b0;
            if (acc) begin
                if (i == n-1) done = 1;
                else i++;
            end
            if (!done) begin
                chk("no_pulse", VW'(pkt_fea_valid), '0);
                chk("vec_hold", fea_vec, m_vec);
            end
        end
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        if (!done) chk("pkt_timeout", '0, VW'(1));
        model_publish();
        chk("pulse", VW'(pkt_fea_valid), VW'(1));
        chk("ready_done", VW'(sif.s_ready), '0);
        chk("vec", fea_vec, m_vec);
        chk("len", VW'(fea_len), VW'(m_len));
        chk("cnt", VW'(pkt_cnt), VW'(m_cnt));
        chk("err_short", VW'(err_short), VW'(m_short));
        chk("err_over", VW'(err_overlen), VW'(m_over));
        fetch_pkt_fea = 1'b1;
        repeat (linger + 1) begin
            @(posedge clk); #1;
            chk("linger_pulse", VW'(pkt_fea_valid), '0);
            chk("linger_ready", VW'(sif.s_ready), '0);
        end
        fetch_pkt_fea = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", VW'(sif.s_ready), '0);
        chk("idle_vec", fea_vec, m_vec);
    endtask

    initial begin
        int n;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.s_last  = 1'b0;
        m_vec = '0; m_len = 0; m_cnt = 0; m_short = 0; m_over = 0;
        #1;
        chk_reset_vals("rst");
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        pkt_q = {};
        for (int i = 1; i <= 8; i++) pkt_q.push_back(DW'(i));
        run_pkt(0, 1, 0);
        chk("full_vec", fea_vec, 64'h0807060504030201);

        pkt_q = {8'hAA, 8'hBB};
        run_pkt(0, 2, 0);
        chk("short_vec", fea_vec, 64'h000000000000BBAA);
        chk("short_cnt", VW'(pkt_cnt), VW'(2));

        pkt_q = {};
        for (int i = 'h10; i <= 'h1A; i++) pkt_q.push_back(DW'(i));
        run_pkt(0, 2, 0);
        chk("over_vec", fea_vec, 64'h1716151413121110);

        for (int p = 0; p < 30; p++) begin
            pkt_q = {};
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++)
                pkt_q.push_back(DW'($urandom));
            run_pkt($urandom_range(0, 50), $urandom_range(0, 2),
                    1'($urandom_range(0, 1)));
        end

        fetch_pkt_fea = 1'b1;
        @(posedge clk); #1;
        chk("mid_ready", VW'(sif.s_ready), VW'(1));
        for (int i = 0; i < 3; i++) begin
            sif.s_valid = 1'b1;
            sif.s_data  = DW'(8'h40 + i);
            @(posedge clk); #1;
        end
        sif.s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_vec = '0; m_len = 0; m_cnt = 0; m_short = 0; m_over = 0;
        chk_reset_vals("midrst");
        fetch_pkt_fea = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_valid", VW'(pkt_fea_valid), '0);

        pkt_q = {};
        for (int i = 0; i < 8; i++) pkt_q.push_back(DW'(8'hC0 + i));
        run_pkt(20, 1, 0);
        chk("post_rst_cnt", VW'(pkt_cnt), VW'(1));
        chk("post_rst_vec", fea_vec, 64'hC7C6C5C4C3C2C1C0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
